serial_chan_arbiter: RTL and testbench
======================================

Name: serial_chan_arbiter

Overview:
- Shares the single internal byte bus among N_CHAN RS232 channel instances in the multi-serial block.
- Picks the most urgent pending RX or TX request from the per-channel priority outputs, breaking ties round-robin.
- Sequences one byte transfer per grant: RX channel -> host, or host -> TX channel.
- Also fans out per-channel error flags and flag-clear strobes.

Parameters:
- N_CHAN, 8, number of serial channels served.
- D_W, 8, byte width.
- PRIORITY_LEVELS, 8, priority encoding range; PRIO_W = $clog2(PRIORITY_LEVELS), CID_W = $clog2(N_CHAN).
- TIMEOUT_CYC, 1024, TX host-wait limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  arbiter enable.
- ch_prio_rx  in  N_CHAN*PRIO_W  per-channel RX urgency; 0 = nothing pending.
- ch_prio_tx  in  N_CHAN*PRIO_W  per-channel TX urgency; 0 = no space or nothing wanted.
- ch_errors  in  N_CHAN*4  per-channel {tx_rd,tx_wr,rx_rd,rx_wr} error flags.
- ch_data_out  in  N_CHAN*D_W  per-channel RX bytes.
- ch_active  out  N_CHAN  one-hot grant.
- ch_commit_read  out  N_CHAN  one-cycle RX pop strobe.
- ch_commit_write  out  N_CHAN  one-cycle TX push strobe.
- ch_clear_flags  out  N_CHAN  one-cycle flag-clear strobe.
- ch_data_in  out  D_W  TX byte, broadcast to all channels.
- host_rx_data  out  D_W  byte delivered to host.
- host_rx_chan  out  CID_W  source channel of host_rx_data.
- host_rx_valid  out  1  host RX byte valid.
- host_rx_ready  in  1  host accepts RX byte.
- host_tx_req  out  1  arbiter requests a TX byte.
- host_tx_chan  out  CID_W  channel the TX byte is for.
- host_tx_data  in  D_W  TX byte from host.
- host_tx_valid  in  1  host_tx_data valid.
- host_clear  in  1  clear request.
- host_clear_chan  in  CID_W  channel to clear.
- err_mask  out  N_CHAN  OR of each channel's 4 error bits.
- err_any  out  1  OR of err_mask.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_n low): FSM=IDLE; rr_ptr=0; all outputs 0.
- err_mask and err_any are combinational from ch_errors and are not gated by enable.
- FSM states: IDLE, RD, RX_HOLD, TX_REQ, WR.
- Winner selection in IDLE:
  - Runs every cycle while enable=1.
  - Winner is the highest nonzero value among all 2*N_CHAN priorities.
  - Equal value: RX beats TX.
  - Still tied: first channel at or after rr_ptr, scanning upward modulo N_CHAN.
  - Winner id and direction are registered.
  - Next state is RD for RX, TX_REQ for TX.
- RD:
  - ch_active[id]=1 and ch_commit_read[id]=1 for exactly 1 cycle.
  - Next cycle: ch_data_out[id] is latched into host_rx_data, host_rx_valid=1, state RX_HOLD.
- RX_HOLD:
  - host_rx_data, host_rx_chan and host_rx_valid stay stable until host_rx_ready=1.
  - On host_rx_ready=1: valid drops, rr_ptr=id+1 (wraps at N_CHAN), state IDLE.
- RX latency: request visible in IDLE at cycle N -> commit_read at N+1 -> host_rx_valid at N+2.
- TX_REQ:
  - host_tx_req=1, host_tx_chan=id, ch_active[id]=1.
  - On host_tx_valid=1: byte is latched, state WR.
- WR:
  - ch_data_in=latched byte, ch_commit_write[id]=1 for exactly 1 cycle.
  - rr_ptr=id+1, state IDLE.
  - ch_data_in holds its last value otherwise.
- Throughput: no back-to-back grant. IDLE always occupies at least one cycle between transactions, so priorities are re-evaluated after the channel updates its FIFO levels.
- Clear strobe: host_clear=1 drives ch_clear_flags[host_clear_chan]=1 on the following cycle for 1 cycle. This is independent of FSM state and of enable. A host_clear_chan >= N_CHAN is ignored.
- enable=0 mid-transaction:
  - Next cycle: FSM=IDLE, all strobes, valid and req low.
  - Latched byte is discarded; rr_ptr unchanged.
  - A pop already issued in RD is lost, by design.
- Priority change after grant: the latched grant is kept and not re-evaluated until IDLE.
- Request from a channel whose id >= N_CHAN is impossible by construction.

Optional Feature:
- Macro SERIAL_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in TX_REQ.
  - If TX_REQ has lasted TIMEOUT_CYC cycles with no host_tx_valid, the FSM returns to IDLE without a write.
  - rr_ptr=id+1.
  - Sticky output timeout_flag (1 bit, extra port) is set; it is cleared by host_clear for any channel.
- Undefined: TX_REQ waits indefinitely; no counter, no timeout_flag port.

Decomposition:
- Shared package serial_mux_pkg holds:
  - FSM state enum.
  - Error-bit index constants TX_RD=3, TX_WR=2, RX_RD=1, RX_WR=0.
  - Direction enum {DIR_RX, DIR_TX}.
- One sub-module, prio_rr_picker: purely combinational. Takes 2*N_CHAN priorities and rr_ptr; returns valid, id and direction.

Test Plan:
- Ch3 prio_rx=5, all others 0, host_rx_ready tied 1 -> commit_read[3] at N+1, host_rx_valid with host_rx_chan=3 and host_rx_data=ch_data_out[3] at N+2, IDLE at N+3.
- Ch1 and ch6 prio_rx=4, rr_ptr=2 -> ch6 served first, then ch1. Repeat with rr_ptr=7 -> ch1 first.
- Ch2 prio_tx=6, ch5 prio_rx=6 -> RX on ch5 wins. Then host_tx_req with chan=2; host gives 0xA5 after 3 cycles -> commit_write[2] for 1 cycle with ch_data_in=0xA5.
- host_rx_ready held 0 for 10 cycles -> data and valid stable throughout, no second commit_read. Drop enable in RX_HOLD -> valid low next cycle, FSM IDLE.
- ch_errors bit 9 set (ch2 rx_rd) -> err_mask=0x04, err_any=1. host_clear with chan=2 -> ch_clear_flags=0x04 for exactly 1 cycle.
- With SERIAL_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: TX grant, no host_tx_valid -> IDLE after 16 cycles, no commit_write, timeout_flag=1.

Source files
------------

// File: rtl/serial_mux_pkg.sv
// Shared types and constants for the multi-serial channel arbiter.
// Error nibble layout per channel is {tx_rd,tx_wr,rx_rd,rx_wr}.
package serial_mux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RX_HOLD,
    TX_REQ,
    WR
  } state_t;

  typedef enum logic {
    DIR_RX,
    DIR_TX
  } dir_t;

  localparam int TX_RD = 3;
  localparam int TX_WR = 2;
  localparam int RX_RD = 1;
  localparam int RX_WR = 0;

endpackage

// File: rtl/serial_chan_arbiter_if.sv
// Host-side byte handshake bundle of the serial channel arbiter.
// master = arbiter side, slave = host side.
interface serial_chan_arbiter_if #(
  parameter int N_CHAN = 8,
  parameter int D_W    = 8
);
  localparam int CID_W = $clog2(N_CHAN);

  logic [D_W-1:0]   host_rx_data;
  logic [CID_W-1:0] host_rx_chan;
  logic             host_rx_valid;
  logic             host_rx_ready;
  logic             host_tx_req;
  logic [CID_W-1:0] host_tx_chan;
  logic [D_W-1:0]   host_tx_data;
  logic             host_tx_valid;
  logic             host_clear;
  logic [CID_W-1:0] host_clear_chan;

  modport master (
    output host_rx_data,
    output host_rx_chan,
    output host_rx_valid,
    input  host_rx_ready,
    output host_tx_req,
    output host_tx_chan,
    input  host_tx_data,
    input  host_tx_valid,
    input  host_clear,
    input  host_clear_chan
  );

  modport slave (
    input  host_rx_data,
    input  host_rx_chan,
    input  host_rx_valid,
    output host_rx_ready,
    input  host_tx_req,
    input  host_tx_chan,
    output host_tx_data,
    output host_tx_valid,
    output host_clear,
    output host_clear_chan
  );

endinterface

// File: rtl/serial_chan_arbiter_picker.sv
// Combinational winner pick: highest priority, RX over TX on equal value,
// then round-robin from rr_ptr upward.
import serial_mux_pkg::*;

module prio_rr_picker #(
  parameter int N_CHAN = 8,
  parameter int PRIO_W = 3,
  parameter int CID_W  = 3
) (
  input  logic [N_CHAN*PRIO_W-1:0] prio_rx,
  input  logic [N_CHAN*PRIO_W-1:0] prio_tx,
  input  logic [CID_W-1:0]         rr_ptr,
  output logic                     valid,
  output logic [CID_W-1:0]         id,
  output dir_t                     dir
);

  logic [PRIO_W-1:0] best;
  logic [N_CHAN-1:0] rx_hit;
  logic [N_CHAN-1:0] tx_hit;
  logic [N_CHAN-1:0] hit;
  logic              found;
  int                j;

  always_comb begin
    best   = '0;
    rx_hit = '0;
    tx_hit = '0;
    hit    = '0;
    found  = 1'b0;
    j      = 0;
    id     = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (prio_rx[i*PRIO_W +: PRIO_W] > best)
        best = prio_rx[i*PRIO_W +: PRIO_W];
      if (prio_tx[i*PRIO_W +: PRIO_W] > best)
        best = prio_tx[i*PRIO_W +: PRIO_W];
    end
    for (int i = 0; i < N_CHAN; i++) begin
      rx_hit[i] = (best != '0) &&
                  (prio_rx[i*PRIO_W +: PRIO_W] == best);
      tx_hit[i] = (best != '0) &&
                  (prio_tx[i*PRIO_W +: PRIO_W] == best);
    end
    valid = (|rx_hit) || (|tx_hit);
    dir   = (|rx_hit) ? DIR_RX : DIR_TX;
    hit   = (|rx_hit) ? rx_hit : tx_hit;
    // scan upward from rr_ptr, wrapping at N_CHAN
    for (int k = 0; k < N_CHAN; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_CHAN)
        j = j - N_CHAN;
      if (!found && hit[j]) begin
        id    = CID_W'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_chan_arbiter.sv
// Byte-bus arbiter for the multi-serial block: one RX or TX byte per grant.
// Optional TX host-wait timeout under SERIAL_ARB_TIMEOUT_EN.
import serial_mux_pkg::*;

module serial_chan_arbiter #(
  parameter int N_CHAN          = 8,
  parameter int D_W             = 8,
  parameter int PRIORITY_LEVELS = 8,
  parameter int TIMEOUT_CYC     = 1024,
  localparam int PRIO_W = $clog2(PRIORITY_LEVELS),
  localparam int CID_W  = $clog2(N_CHAN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [N_CHAN*PRIO_W-1:0] ch_prio_rx,
  input  logic [N_CHAN*PRIO_W-1:0] ch_prio_tx,
  input  logic [N_CHAN*4-1:0]      ch_errors,
  input  logic [N_CHAN*D_W-1:0]    ch_data_out,
  output logic [N_CHAN-1:0]        ch_active,
  output logic [N_CHAN-1:0]        ch_commit_read,
  output logic [N_CHAN-1:0]        ch_commit_write,
  output logic [N_CHAN-1:0]        ch_clear_flags,
  output logic [D_W-1:0]           ch_data_in,
  serial_chan_arbiter_if.master    host,
  output logic [N_CHAN-1:0]        err_mask,
  output logic                     err_any,
`ifdef SERIAL_ARB_TIMEOUT_EN
  output logic                     timeout_flag,
`endif
  output logic                     busy
);

  state_t            state;
  logic [CID_W-1:0]  rr_ptr;
  logic [CID_W-1:0]  id_q;
  logic [CID_W-1:0]  next_ptr;
  logic              pick_valid;
  logic [CID_W-1:0]  pick_id;
  dir_t              pick_dir;
  logic [N_CHAN-1:0] pick_oh;
  logic [N_CHAN-1:0] sel_oh;
  logic              tmo_hit;

  prio_rr_picker #(
    .N_CHAN (N_CHAN),
    .PRIO_W (PRIO_W),
    .CID_W  (CID_W)
  ) u_picker (
    .prio_rx (ch_prio_rx),
    .prio_tx (ch_prio_tx),
    .rr_ptr  (rr_ptr),
    .valid   (pick_valid),
    .id      (pick_id),
    .dir     (pick_dir)
  );

  always_comb begin
    pick_oh = '0;
    sel_oh  = '0;
    pick_oh[pick_id] = 1'b1;
    sel_oh[id_q]     = 1'b1;
  end

  always_comb begin
    err_mask = '0;
    for (int i = 0; i < N_CHAN; i++)
      err_mask[i] = ch_errors[i*4+TX_RD] |
                    ch_errors[i*4+TX_WR] |
                    ch_errors[i*4+RX_RD] |
                    ch_errors[i*4+RX_WR];
    err_any = |err_mask;
  end

  assign next_ptr = (id_q == CID_W'(N_CHAN-1)) ?
                    '0 : id_q + 1'b1;
  assign busy = (state != IDLE);

`ifdef SERIAL_ARB_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_CYC + 1);
  logic [TC_W-1:0] tcnt;

  assign tmo_hit = (state == TX_REQ) && !host.host_tx_valid &&
                   (tcnt == TC_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (enable && state == TX_REQ)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
      if (enable && tmo_hit)
        timeout_flag <= 1'b1;
      else if (host.host_clear)
        timeout_flag <= 1'b0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      id_q               <= '0;
      ch_active          <= '0;
      ch_commit_read     <= '0;
      ch_commit_write    <= '0;
      ch_data_in         <= '0;
      host.host_rx_data  <= '0;
      host.host_rx_chan  <= '0;
      host.host_rx_valid <= 1'b0;
      host.host_tx_req   <= 1'b0;
      host.host_tx_chan  <= '0;
    end else if (!enable) begin
      // abort: any latched byte is dropped, rr_ptr kept
      state              <= IDLE;
      ch_active          <= '0;
      ch_commit_read     <= '0;
      ch_commit_write    <= '0;
      host.host_rx_valid <= 1'b0;
      host.host_tx_req   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            id_q      <= pick_id;
            ch_active <= pick_oh;
            if (pick_dir == DIR_RX) begin
              ch_commit_read <= pick_oh;
              state          <= RD;
            end else begin
              host.host_tx_req  <= 1'b1;
              host.host_tx_chan <= pick_id;
              state             <= TX_REQ;
            end
          end
        end
        RD: begin
          ch_active          <= '0;
          ch_commit_read     <= '0;
          host.host_rx_data  <= ch_data_out[id_q*D_W +: D_W];
          host.host_rx_chan  <= id_q;
          host.host_rx_valid <= 1'b1;
          state              <= RX_HOLD;
        end
        RX_HOLD: begin
          if (host.host_rx_ready) begin
            host.host_rx_valid <= 1'b0;
            rr_ptr             <= next_ptr;
            state              <= IDLE;
          end
        end
        TX_REQ: begin
          if (host.host_tx_valid) begin
            host.host_tx_req <= 1'b0;
            ch_data_in       <= host.host_tx_data;
            ch_commit_write  <= sel_oh;
            state            <= WR;
          end else if (tmo_hit) begin
            host.host_tx_req <= 1'b0;
            ch_active        <= '0;
            rr_ptr           <= next_ptr;
            state            <= IDLE;
          end
        end
        WR: begin
          ch_active       <= '0;
          ch_commit_write <= '0;
          rr_ptr          <= next_ptr;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // clear strobes bypass both the FSM and enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_clear_flags <= '0;
    end else begin
      ch_clear_flags <= '0;
      if (host.host_clear && (int'(host.host_clear_chan) < N_CHAN))
        ch_clear_flags[host.host_clear_chan] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_chan_arbiter.sv
// Directed bench for serial_chan_arbiter (default build, 8 channels).
// Expected values are hand-derived from the arbitration rules.
module tb_serial_chan_arbiter;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int PW = 3;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [N*PW-1:0] ch_prio_rx;
  logic [N*PW-1:0] ch_prio_tx;
  logic [N*4-1:0]  ch_errors;
  logic [N*DW-1:0] ch_data_out;
  logic [N-1:0]    ch_active;
  logic [N-1:0]    ch_commit_read;
  logic [N-1:0]    ch_commit_write;
  logic [N-1:0]    ch_clear_flags;
  logic [DW-1:0]   ch_data_in;
  logic [N-1:0]    err_mask;
  logic            err_any;
  logic            busy;

  logic [PW-1:0] prx [N];
  logic [PW-1:0] ptx [N];

  int n_checks = 0;
  int n_fail   = 0;

  serial_chan_arbiter_if #(.N_CHAN(N), .D_W(DW)) hif ();

  serial_chan_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .ch_prio_rx      (ch_prio_rx),
    .ch_prio_tx      (ch_prio_tx),
    .ch_errors       (ch_errors),
    .ch_data_out     (ch_data_out),
    .ch_active       (ch_active),
    .ch_commit_read  (ch_commit_read),
    .ch_commit_write (ch_commit_write),
    .ch_clear_flags  (ch_clear_flags),
    .ch_data_in      (ch_data_in),
    .host            (hif),
    .err_mask        (err_mask),
    .err_any         (err_any),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    ch_prio_rx = '0;
    ch_prio_tx = '0;
    for (int i = 0; i < N; i++) begin
      ch_prio_rx[i*PW +: PW] = prx[i];
      ch_prio_tx[i*PW +: PW] = ptx[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one RX grant with host_rx_ready held high
  task automatic serve_rx(input int ch);
    logic [N-1:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    tick();
    check($sformatf("rd_strobe_ch%0d", ch), 32'(ch_commit_read), 32'(oh));
    check($sformatf("rd_active_ch%0d", ch), 32'(ch_active), 32'(oh));
    prx[ch] = '0;
    tick();
    check($sformatf("rx_valid_ch%0d", ch), 32'(hif.host_rx_valid), 32'd1);
    check($sformatf("rx_chan_ch%0d", ch), 32'(hif.host_rx_chan), 32'(ch));
    check($sformatf("rx_data_ch%0d", ch), 32'(hif.host_rx_data), 32'h30 + 32'(ch));
    check($sformatf("rd_once_ch%0d", ch), 32'(ch_commit_read), 32'd0);
    tick();
    check($sformatf("idle_after_ch%0d", ch), 32'(busy), 32'd0);
    check($sformatf("valid_drop_ch%0d", ch), 32'(hif.host_rx_valid), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    ch_errors = '0;
    for (int i = 0; i < N; i++) begin
      prx[i] = '0;
      ptx[i] = '0;
      ch_data_out[i*DW +: DW] = 8'h30 + 8'(i);
    end
    hif.host_rx_ready   = 1'b1;
    hif.host_tx_data    = '0;
    hif.host_tx_valid   = 1'b0;
    hif.host_clear      = 1'b0;
    hif.host_clear_chan = '0;
    tick();
    tick();
    check("rst_active", 32'(ch_active), 32'd0);
    check("rst_valid", 32'(hif.host_rx_valid), 32'd0);
    check("rst_txreq", 32'(hif.host_tx_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_in", 32'(ch_data_in), 32'd0);
    check("rst_clear", 32'(ch_clear_flags), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    enable = 1'b1;

    // single RX request on ch3; rr_ptr goes 0 -> 4
    prx[3] = 3'd5;
    serve_rx(3);

    // serve ch1 alone so rr_ptr = 2
    prx[1] = 3'd4;
    serve_rx(1);
    // tie ch1/ch6 from rr_ptr=2: ch6 then ch1
    prx[1] = 3'd4;
    prx[6] = 3'd4;
    serve_rx(6);
    serve_rx(1);
    // ch6 alone -> rr_ptr = 7; tie again: ch1 then ch6
    prx[6] = 3'd4;
    serve_rx(6);
    prx[1] = 3'd4;
    prx[6] = 3'd4;
    serve_rx(1);
    serve_rx(6);

    // equal RX/TX: RX ch5 wins, then TX ch2
    ptx[2] = 3'd6;
    prx[5] = 3'd6;
    serve_rx(5);
    tick();
    check("tx_req", 32'(hif.host_tx_req), 32'd1);
    check("tx_chan", 32'(hif.host_tx_chan), 32'd2);
    check("tx_active", 32'(ch_active), 32'h04);
    ptx[2] = 3'd7;
    tick();
    tick();
    check("tx_req_wait", 32'(hif.host_tx_req), 32'd1);
    check("tx_no_write", 32'(ch_commit_write), 32'd0);
    check("tx_grant_kept", 32'(hif.host_tx_chan), 32'd2);
    hif.host_tx_data  = 8'hA5;
    hif.host_tx_valid = 1'b1;
    tick();
    hif.host_tx_valid = 1'b0;
    hif.host_tx_data  = 8'h00;
    ptx[2] = '0;
    check("wr_strobe", 32'(ch_commit_write), 32'h04);
    check("wr_data", 32'(ch_data_in), 32'hA5);
    check("wr_req_low", 32'(hif.host_tx_req), 32'd0);
    tick();
    check("wr_once", 32'(ch_commit_write), 32'd0);
    check("wr_idle", 32'(busy), 32'd0);
    check("data_in_hold", 32'(ch_data_in), 32'hA5);

    // host stalls RX for 10 cycles, then enable drops (rr_ptr = 3)
    hif.host_rx_ready = 1'b0;
    prx[0] = 3'd7;
    tick();
    check("stall_rd", 32'(ch_commit_read), 32'h01);
    prx[0] = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_valid", 32'(hif.host_rx_valid), 32'd1);
      check("stall_data", 32'(hif.host_rx_data), 32'h30);
      check("stall_no_rd", 32'(ch_commit_read), 32'd0);
    end
    enable = 1'b0;
    tick();
    check("abort_valid", 32'(hif.host_rx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    hif.host_rx_ready = 1'b1;

    // ch2 and ch4 tie after abort: rr_ptr still 3 -> ch4 first
    prx[2] = 3'd2;
    prx[4] = 3'd2;
    serve_rx(4);
    serve_rx(2);

    // higher TX value beats lower RX value
    prx[4] = 3'd2;
    ptx[7] = 3'd3;
    tick();
    check("tx_over_rx", 32'(hif.host_tx_chan), 32'd7);
    check("tx_over_rx_req", 32'(hif.host_tx_req), 32'd1);
    enable = 1'b0;
    prx[4] = '0;
    ptx[7] = '0;
    tick();
    check("tx_abort_req", 32'(hif.host_tx_req), 32'd0);
    check("tx_abort_active", 32'(ch_active), 32'd0);

    // error fan-out and clear strobe, with enable still low
    ch_errors = 32'h0000_0200;
    #1;
    check("err_mask", 32'(err_mask), 32'h04);
    check("err_any", 32'(err_any), 32'd1);
    ch_errors = 32'h1000_0000;
    #1;
    check("err_mask_ch7", 32'(err_mask), 32'h80);
    ch_errors = '0;
    #1;
    check("err_none", 32'(err_any), 32'd0);
    hif.host_clear      = 1'b1;
    hif.host_clear_chan = 3'd2;
    tick();
    hif.host_clear = 1'b0;
    check("clear_pulse", 32'(ch_clear_flags), 32'h04);
    tick();
    check("clear_once", 32'(ch_clear_flags), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
